bus_arbiter: RTL and testbench

- Shares the single external instruction/data bus (ROM/RAM slave) between the IF fetch port and the MEM load/store port.
- Sequences one transaction at a time with a small FSM and holds the slave request stable until ack.
- Returns data and ack to the winning port and raises stallreq_from_if / stallreq_from_mem toward the pipeline control unit.
- Honours pipeline flush by discarding in-flight fetches.

---
 rtl/bus_arbiter_pkg.sv | 19 +
 rtl/bus_arbiter_watchdog.sv | 40 ++++
 rtl/bus_arbiter.sv | 161 ++++++++++++++++
 tb/tb_bus_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared constants for the instruction/data bus arbiter: reset level, FSM state
// encodings and the watchdog counter sizing helper.
package bus_arbiter_pkg;

  localparam logic RST_ENABLE = 1'b1;

  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_IF   = 2'd1;
  localparam logic [1:0] ARB_MEM  = 2'd2;
  localparam logic [1:0] ARB_DROP = 2'd3;

  // Watchdog counter width: wide enough for TMO_CYCLES-1, never below 8 bits.
  function automatic int wd_width(input int tmo);
    int w;
    w = $clog2(tmo);
    return (w < 8) ? 8 : w;
  endfunction

endpackage

// File: rtl/bus_arbiter_watchdog.sv
// arb_watchdog: counts cycles spent waiting for bus_ack and flags expiry at
// TMO_CYCLES-1. Only instantiated when ARB_TIMEOUT_EN is defined.
module arb_watchdog
  import bus_arbiter_pkg::*;
#(
  parameter int TMO_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic active_i,
  input  logic ack_i,
  output logic expired_o
);

  localparam int CW = wd_width(TMO_CYCLES);
  localparam logic [CW-1:0] LIMIT = CW'(TMO_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = '0;
    end else if (active_i && !ack_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = active_i & ~ack_i & (cnt_q == LIMIT);

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one slave bus between the IF fetch port and the MEM
// load/store port, MEM first. Define ARB_TIMEOUT_EN to add the ack watchdog.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int TMO_CYCLES = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ack,
  input  logic                mem_req,
  input  logic                mem_we,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W/8-1:0] mem_sel,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                mem_ack,
  output logic                bus_req,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_sel,
  input  logic [DATA_W-1:0]   bus_rdata,
  input  logic                bus_ack,
  output logic                stallreq_from_if,
  output logic                stallreq_from_mem,
  output logic                bus_err
);

  localparam int SEL_W = DATA_W / 8;

  if (TMO_CYCLES < 2) begin : g_bad_tmo
    $error("bus_arbiter: TMO_CYCLES must be at least 2");
  end

  logic [1:0]        state_q, state_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [SEL_W-1:0]  bus_sel_q, bus_sel_d;
  logic              timeout;
  logic              done;
  logic              if_discard;

`ifdef ARB_TIMEOUT_EN
  logic wd_start;
  logic bus_err_q;

  assign wd_start = (state_q == ARB_IDLE) && (state_d != ARB_IDLE);

  arb_watchdog #(.TMO_CYCLES(TMO_CYCLES)) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .start_i   (wd_start),
    .active_i  (state_q != ARB_IDLE),
    .ack_i     (bus_ack),
    .expired_o (timeout)
  );

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= timeout;
    end
  end
  assign bus_err = bus_err_q;
`else
  assign timeout = 1'b0;
  assign bus_err = 1'b0;
`endif

  // A fetch whose requester has gone away (flush or dropped if_req) is discarded.
  assign if_discard = flush | ~if_req;
  assign done       = bus_ack | timeout;

  assign if_ack    = (state_q == ARB_IF) & ~if_discard & done;
  assign mem_ack   = (state_q == ARB_MEM) & done;
  assign if_rdata  = (if_ack & bus_ack) ? bus_rdata : '0;
  assign mem_rdata = (mem_ack & bus_ack) ? bus_rdata : '0;

  assign stallreq_from_if  = if_req & ~if_ack;
  assign stallreq_from_mem = mem_req & ~mem_ack;

  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_sel_d   = bus_sel_q;
    case (state_q)
      ARB_IDLE: begin
        if (mem_req) begin
          bus_req_d   = 1'b1;
          bus_we_d    = mem_we;
          bus_addr_d  = mem_addr;
          bus_wdata_d = mem_wdata;
          bus_sel_d   = mem_sel;
          state_d     = ARB_MEM;
        end else if (if_req && !flush) begin
          bus_req_d  = 1'b1;
          bus_we_d   = 1'b0;
          bus_addr_d = if_addr;
          bus_sel_d  = '1;
          state_d    = ARB_IF;
        end
      end
      ARB_IF: begin
        if (done) begin
          bus_req_d = 1'b0;
          state_d   = ARB_IDLE;
        end else if (if_discard) begin
          state_d = ARB_DROP;
        end
      end
      ARB_MEM, ARB_DROP: begin
        if (done) begin
          bus_req_d = 1'b0;
          state_d   = ARB_IDLE;
        end
      end
      default: begin
        bus_req_d = 1'b0;
        state_d   = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q     <= ARB_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_sel_q   <= '0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_sel_q   <= bus_sel_d;
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_sel   = bus_sel_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: a slave model, random IF/MEM traffic and a
// negedge monitor comparing bus requests and port acks against queued expectations.
`timescale 1ns/1ps
module tb_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic [DW-1:0] if_rdata;
  logic          if_ack;
  logic          mem_req = 1'b0;
  logic          mem_we = 1'b0;
  logic [AW-1:0] mem_addr = '0;
  logic [DW-1:0] mem_wdata = '0;
  logic [SW-1:0] mem_sel = '0;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic          bus_req;
  logic          bus_we;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic [SW-1:0] bus_sel;
  logic [DW-1:0] bus_rdata = '0;
  logic          bus_ack = 1'b0;
  logic          stallreq_from_if;
  logic          stallreq_from_mem;
  logic          bus_err;

  bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TMO_CYCLES(256)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_sel(mem_sel), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_sel(bus_sel), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .stallreq_from_if(stallreq_from_if), .stallreq_from_mem(stallreq_from_mem),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            port;   // 0 = IF, 1 = MEM
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] sel;
  } bus_txn_t;

  typedef struct {
    bit            port;
    logic [DW-1:0] data;
  } ack_t;

  bus_txn_t bus_q[$];
  ack_t     ack_q[$];
  int checks = 0;
  int failures = 0;

  // Slave model state; cur_* describes the transfer currently on the bus.
  int slave_delay_force = 0;
  bit slave_busy = 1'b0;
  int slave_cnt = 0;
  bit cur_port = 1'b0;
  bit cur_dropped = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave: acks 1..4 cycles (or a forced count) after seeing bus_req.
  always @(posedge clk) begin
    ack_t a;
    #1;
    bus_ack = 1'b0;
    if (slave_busy) begin
      slave_cnt--;
      if (slave_cnt == 0) begin
        bus_ack    = 1'b1;
        bus_rdata  = $urandom;
        slave_busy = 1'b0;
        if (!cur_dropped) begin
          a.port = cur_port;
          a.data = bus_rdata;
          ack_q.push_back(a);
        end
        cur_dropped = 1'b1;
      end
    end else if (bus_req) begin
      slave_busy = 1'b1;
      slave_cnt  = (slave_delay_force > 0) ? slave_delay_force : int'($urandom_range(1, 4));
    end
  end

  // Monitor
  logic          prev_req = 1'b0;
  logic          prev_ack_req = 1'b0;
  logic [AW-1:0] snap_addr;
  logic          snap_we;
  logic [SW-1:0] snap_sel;
  logic [DW-1:0] snap_wdata;

  always @(negedge clk) begin
    bit exp_if, exp_mem;
    ack_t a;
    bus_txn_t e;
    if (!rst) begin
      exp_if  = bus_ack && (ack_q.size() > 0) && (ack_q[0].port == 1'b0);
      exp_mem = bus_ack && (ack_q.size() > 0) && (ack_q[0].port == 1'b1);
      check("if_ack", if_ack, exp_if);
      check("mem_ack", mem_ack, exp_mem);
      if (exp_if || exp_mem) begin
        a = ack_q.pop_front();
        if (exp_if) check("if_rdata", if_rdata, a.data);
        else        check("mem_rdata", mem_rdata, a.data);
      end
      if (!exp_if)  check("if_rdata_zero", if_rdata, 0);
      if (!exp_mem) check("mem_rdata_zero", mem_rdata, 0);
      check("stallreq_from_if", stallreq_from_if, if_req && !exp_if);
      check("stallreq_from_mem", stallreq_from_mem, mem_req && !exp_mem);
      check("bus_err", bus_err, 0);
      if (prev_ack_req) check("bus_req_drop_after_ack", bus_req, 0);
      if (bus_req && !prev_req) begin
        check("bus_req_expected", bus_q.size() > 0, 1);
        if (bus_q.size() > 0) begin
          e = bus_q.pop_front();
          check("bus_we", bus_we, e.we);
          check("bus_addr", bus_addr, e.addr);
          check("bus_sel", bus_sel, e.sel);
          if (e.we) check("bus_wdata", bus_wdata, e.wdata);
          $display("bus txn port=%s we=%0d addr=%h wdata=%h sel=%h",
                   e.port ? "MEM" : "IF", bus_we, bus_addr, bus_wdata, bus_sel);
          snap_addr   = e.addr;
          snap_we     = e.we;
          snap_sel    = e.sel;
          snap_wdata  = bus_wdata;
          cur_port    = e.port;
          cur_dropped = 1'b0;
        end
      end else if (bus_req && prev_req) begin
        check("hold_addr", bus_addr, snap_addr);
        check("hold_we", bus_we, snap_we);
        check("hold_sel", bus_sel, snap_sel);
        check("hold_wdata", bus_wdata, snap_wdata);
      end
    end
    prev_req     = bus_req;
    prev_ack_req = bus_ack && bus_req;
  end

  task automatic issue_if(input logic [AW-1:0] a);
    bus_txn_t e;
    if_addr = a;
    if_req  = 1'b1;
    e.port = 1'b0; e.we = 1'b0; e.addr = a; e.wdata = '0; e.sel = '1;
    bus_q.push_back(e);
  endtask

  task automatic issue_mem(input bit we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [SW-1:0] s);
    bus_txn_t e;
    mem_we = we; mem_addr = a; mem_wdata = d; mem_sel = s;
    mem_req = 1'b1;
    e.port = 1'b1; e.we = we; e.addr = a; e.wdata = d; e.sel = s;
    bus_q.push_back(e);
  endtask

  // Holds each request until its ack, then lets the bus drain.
  task automatic wait_done();
    int n;
    bit gi, gm;
    n = 0;
    while ((if_req || mem_req) && n < 200) begin
      @(negedge clk);
      gi = if_ack;
      gm = mem_ack;
      @(posedge clk); #2;
      if (gi) if_req = 1'b0;
      if (gm) mem_req = 1'b0;
      n++;
    end
    check("request_completes", n < 200, 1);
    if_req = 1'b0;
    mem_req = 1'b0;
    n = 0;
    while ((slave_busy || bus_req) && n < 50) begin
      @(posedge clk); #2;
      n++;
    end
    check("bus_drains", n < 50, 1);
    @(posedge clk); #2;
  endtask

  task automatic wait_bus_req();
    int n;
    n = 0;
    while (!bus_req && n < 10) begin
      @(posedge clk); #2;
      n++;
    end
    check("bus_req_rises", bus_req, 1);
  endtask

  task automatic fetch_with_flush(input logic [AW-1:0] a, input int dly);
    slave_delay_force = dly;
    issue_if(a);
    wait_bus_req();
    @(posedge clk); #2;
    flush = 1'b1;
    if_req = 1'b0;
    cur_dropped = 1'b1;
    @(posedge clk); #2;
    flush = 1'b0;
    wait_done();
    slave_delay_force = 0;
  endtask

  initial begin
    int kind;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    check("rst_bus_req", bus_req, 0);
    check("rst_bus_we", bus_we, 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_bus_wdata", bus_wdata, 0);
    check("rst_bus_sel", bus_sel, 0);
    check("rst_if_ack", if_ack, 0);
    check("rst_mem_ack", mem_ack, 0);

    // Single fetch with a two-cycle slave
    slave_delay_force = 2;
    issue_if(32'h100);
    wait_done();
    slave_delay_force = 0;

    // Simultaneous requests: store wins, fetch follows
    issue_mem(1'b1, 32'h2000, 32'hDEADBEEF, 4'hF);
    issue_if(32'h104);
    wait_done();

    // Flush during fetch, then a normal fetch elsewhere
    fetch_with_flush(32'h200, 4);
    issue_if(32'h300);
    wait_done();

    // Flush during store: store must complete untouched
    slave_delay_force = 4;
    issue_mem(1'b1, 32'h2004, 32'hCAFEF00D, 4'h3);
    wait_bus_req();
    @(posedge clk); #2;
    flush = 1'b1;
    @(posedge clk); #2;
    flush = 1'b0;
    wait_done();

    // Reset mid-store; the late slave ack must be ignored
    slave_delay_force = 6;
    issue_mem(1'b1, 32'h3000, 32'h12345678, 4'hF);
    wait_bus_req();
    @(posedge clk); #2;
    rst = 1'b1;
    mem_req = 1'b0;
    cur_dropped = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    check("midrst_bus_req", bus_req, 0);
    check("midrst_bus_we", bus_we, 0);
    check("midrst_bus_addr", bus_addr, 0);
    wait_done();
    slave_delay_force = 0;

    // Random traffic
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 4);
      case (kind)
        0: issue_if($urandom & 32'hFFFF_FFFC);
        1: issue_mem($urandom_range(0, 1), $urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom_range(1, 15)));
        2: begin
          issue_mem($urandom_range(0, 1), $urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom_range(1, 15)));
          issue_if($urandom & 32'hFFFF_FFFC);
        end
        3: begin
          issue_if($urandom & 32'hFFFF_FFFC);
          @(posedge clk); #2;
          issue_mem($urandom_range(0, 1), $urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom_range(1, 15)));
        end
        default: fetch_with_flush($urandom & 32'hFFFF_FFFC, $urandom_range(3, 5));
      endcase
      if (kind != 4) wait_done();
    end

    check("bus_q_empty", bus_q.size(), 0);
    check("ack_q_empty", ack_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
